// File: rtl/adder_pipelined_nbit.sv
// -----------------------------------------------------------------------------
// adder_pipelined_nbit
//
// Pipelined, carry-chained adder/subtractor. The WIDTH-bit operands are cut
// into CHUNK-bit slices. Pipeline stage k adds slice k and registers the slice
// carry for stage k+1, so the result leaves after STAGES = WIDTH/CHUNK stages.
// The whole pipeline advances as one unit: it moves when the output register is
// empty or is being drained, and it holds completely otherwise.
//
// Ports
//   clk        in   1      clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      operands/mode valid this cycle
//   in_ready   out  1      block accepts operands this cycle
//   in1        in   WIDTH  operand A
//   in2        in   WIDTH  operand B
//   carry_in   in   1      carry into bit 0 (add mode only)
//   sub        in   1      0: A+B+carry_in, 1: A-B (A + ~B + 1)
//   out_valid  out  1      result valid
//   out_ready  in   1      downstream accepts result
//   sum        out  WIDTH  result modulo 2^WIDTH
//   carry_out  out  1      carry out of the MSB (sub mode: 1 = no borrow)
//   overflow   out  1      signed overflow of the A + B' addition
// -----------------------------------------------------------------------------
module adder_pipelined_nbit #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             carry_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int STAGES = WIDTH / CHUNK;

    generate
        if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_param_check
            $error("adder_pipelined_nbit: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    // Stage registers. Index k holds what stage k produced: the operands as
    // they travel (upper slices still to be added), the sum with slices 0..k
    // filled in, and the carry out of slice k.
    logic             r_valid [STAGES];
    logic             r_carry [STAGES];
    logic [WIDTH-1:0] r_a     [STAGES];
    logic [WIDTH-1:0] r_b     [STAGES];
    logic [WIDTH-1:0] r_s     [STAGES];
    logic             r_overflow;

    // Stage inputs: stage 0 takes the ports, stage k takes stage k-1's registers.
    logic             w_v_in  [STAGES];
    logic             w_c_in  [STAGES];
    logic [WIDTH-1:0] w_a_in  [STAGES];
    logic [WIDTH-1:0] w_b_in  [STAGES];
    logic [WIDTH-1:0] w_s_in  [STAGES];

    // Per-stage slice adder results.
    logic [CHUNK:0]   w_add   [STAGES];
    logic [WIDTH-1:0] w_s_nxt [STAGES];
    logic             w_overflow_nxt;

    logic             w_adv;
    logic             w_unused_bits;

    // One advance signal for the whole pipe: a stalled output freezes every
    // stage, so a bubble can never be squeezed out and ordering is trivially
    // preserved.
    assign w_adv     = !r_valid[STAGES-1] || out_ready;
    assign in_ready  = w_adv;

    assign out_valid = r_valid[STAGES-1];
    assign sum       = r_s[STAGES-1];
    assign carry_out = r_carry[STAGES-1];
    assign overflow  = r_overflow;

    // Stage input routing. Subtraction is folded in once at the entrance:
    // B is inverted and the +1 enters as the initial carry, carry_in ignored.
    // NOTE: every variable of an always_comb is assigned on every pass (all
    // array elements, no conditional-only writes), otherwise a latch is inferred.
    always_comb begin
        w_v_in[0] = in_valid;
        w_c_in[0] = sub ? 1'b1 : carry_in;
        w_a_in[0] = in1;
        w_b_in[0] = sub ? ~in2 : in2;
        w_s_in[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            w_v_in[k] = r_valid[k-1];
            w_c_in[k] = r_carry[k-1];
            w_a_in[k] = r_a[k-1];
            w_b_in[k] = r_b[k-1];
            w_s_in[k] = r_s[k-1];
        end
    end

    // Slice adders: stage k adds only bits [k*CHUNK +: CHUNK]; the extra top
    // bit of w_add is the slice carry handed to the next stage.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            w_add[k] = {1'b0, w_a_in[k][k*CHUNK +: CHUNK]}
                     + {1'b0, w_b_in[k][k*CHUNK +: CHUNK]}
                     + {{CHUNK{1'b0}}, w_c_in[k]};
            w_s_nxt[k] = w_s_in[k];
            w_s_nxt[k][k*CHUNK +: CHUNK] = w_add[k][CHUNK-1:0];
        end
    end

    // Signed overflow needs only the MSB slice: both operand sign bits (B
    // already inverted for subtraction) agree and the result sign differs.
    always_comb begin
        w_overflow_nxt = (w_a_in[STAGES-1][WIDTH-1] == w_b_in[STAGES-1][WIDTH-1]) &&
                         (w_add[STAGES-1][CHUNK-1] != w_a_in[STAGES-1][WIDTH-1]);
    end

    // Operand slices already consumed, sum slices not yet written and the
    // operands left in the last stage carry no information downstream; they
    // are gathered here so they read as deliberately unused.
    always_comb begin
        w_unused_bits = (^r_a[STAGES-1]) ^ (^r_b[STAGES-1]);
        for (int k = 0; k < STAGES; k++) begin
            w_unused_bits = w_unused_bits ^ (^w_a_in[k]) ^ (^w_b_in[k]) ^ (^w_s_in[k]);
        end
    end

    // Valid bits shift on every advance so bubbles move too. Data only loads
    // behind a valid entry, so the outputs keep their last result across
    // bubbles instead of picking up stale operands.
    // NOTE: the data registers are reset as well, not just the valid bits,
    // because sum/carry_out/overflow are driven straight from the last stage
    // and must read 0 during and after reset.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // stage samples its predecessor's value from before the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                r_valid[k] <= 1'b0;
                r_carry[k] <= 1'b0;
                r_a[k]     <= '0;
                r_b[k]     <= '0;
                r_s[k]     <= '0;
            end
            r_overflow <= 1'b0;
        end else if (w_adv) begin
            for (int k = 0; k < STAGES; k++) begin
                r_valid[k] <= w_v_in[k];
                if (w_v_in[k]) begin
                    r_carry[k] <= w_add[k][CHUNK];
                    r_a[k]     <= w_a_in[k];
                    r_b[k]     <= w_b_in[k];
                    r_s[k]     <= w_s_nxt[k];
                end
            end
            if (w_v_in[STAGES-1]) begin
                r_overflow <= w_overflow_nxt;
            end
        end
    end

endmodule

// File: tb/tb_adder_pipelined_nbit.sv
// -----------------------------------------------------------------------------
// tb_adder_pipelined_nbit
//
// Three instances of the adder share clock and reset:
//   sel 0: WIDTH=32, CHUNK=8  (4 stages)
//   sel 1: WIDTH=4,  CHUNK=4  (1 stage)
//   sel 2: WIDTH=16, CHUNK=4  (4 stages)
// One common set of stimulus signals is steered to the selected instance; the
// others see in_valid=0 and out_ready=1. A monitor on the falling edge pushes
// the expected result of every accepted operation into a queue and pops and
// compares on every output transfer; it also checks that outputs hold while
// stalled. Directed tasks additionally compare values and latency inline.
// -----------------------------------------------------------------------------
module tb_adder_pipelined_nbit;

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  sel;
    logic        t_in_valid, t_out_ready, t_cin, t_sub;
    logic [31:0] t_in1, t_in2;

    logic        d0_in_ready, d0_out_valid, d0_cout, d0_ovf;
    logic [31:0] d0_sum;
    logic        d1_in_ready, d1_out_valid, d1_cout, d1_ovf;
    logic [3:0]  d1_sum;
    logic        d2_in_ready, d2_out_valid, d2_cout, d2_ovf;
    logic [15:0] d2_sum;

    logic        o_in_ready, o_out_valid, o_cout, o_ovf;
    logic [31:0] o_sum;

    int          checks = 0;
    int          errors = 0;
    int          n_out  = 0;
    int          cyc    = 0;
    logic        rand_ready = 1'b0;
    res_t        sb_q[$];
    logic        prev_stall = 1'b0;
    res_t        prev_out;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    adder_pipelined_nbit #(.WIDTH(32), .CHUNK(8)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(t_in_valid && sel == 2'd0), .in_ready(d0_in_ready),
        .in1(t_in1), .in2(t_in2), .carry_in(t_cin), .sub(t_sub),
        .out_valid(d0_out_valid), .out_ready(sel == 2'd0 ? t_out_ready : 1'b1),
        .sum(d0_sum), .carry_out(d0_cout), .overflow(d0_ovf)
    );

    adder_pipelined_nbit #(.WIDTH(4), .CHUNK(4)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(t_in_valid && sel == 2'd1), .in_ready(d1_in_ready),
        .in1(t_in1[3:0]), .in2(t_in2[3:0]), .carry_in(t_cin), .sub(t_sub),
        .out_valid(d1_out_valid), .out_ready(sel == 2'd1 ? t_out_ready : 1'b1),
        .sum(d1_sum), .carry_out(d1_cout), .overflow(d1_ovf)
    );

    adder_pipelined_nbit #(.WIDTH(16), .CHUNK(4)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(t_in_valid && sel == 2'd2), .in_ready(d2_in_ready),
        .in1(t_in1[15:0]), .in2(t_in2[15:0]), .carry_in(t_cin), .sub(t_sub),
        .out_valid(d2_out_valid), .out_ready(sel == 2'd2 ? t_out_ready : 1'b1),
        .sum(d2_sum), .carry_out(d2_cout), .overflow(d2_ovf)
    );

    always_comb begin
        o_in_ready  = d0_in_ready;
        o_out_valid = d0_out_valid;
        o_sum       = d0_sum;
        o_cout      = d0_cout;
        o_ovf       = d0_ovf;
        case (sel)
            2'd1: begin
                o_in_ready = d1_in_ready; o_out_valid = d1_out_valid;
                o_sum = {28'd0, d1_sum}; o_cout = d1_cout; o_ovf = d1_ovf;
            end
            2'd2: begin
                o_in_ready = d2_in_ready; o_out_valid = d2_out_valid;
                o_sum = {16'd0, d2_sum}; o_cout = d2_cout; o_ovf = d2_ovf;
            end
            default: ;
        endcase
    end

    function automatic int w_of(input logic [1:0] s);
        return (s == 2'd0) ? 32 : ((s == 2'd1) ? 4 : 16);
    endfunction

    function automatic int stages_of(input logic [1:0] s);
        return (s == 2'd1) ? 1 : 4;
    endfunction

    function automatic logic [31:0] mask_of(input int w);
        return (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

    // Reference arithmetic: full-width sum in w+1 bits, B inverted plus one
    // for subtraction, overflow from the sign bits of A, B' and the sum.
    function automatic res_t model(input int w, input logic [31:0] a, b,
                                   input logic cin, s);
        logic [32:0] m, aa, bb, full;
        res_t r;
        m    = {1'b0, mask_of(w)};
        aa   = {1'b0, a} & m;
        bb   = s ? (~{1'b0, b} & m) : ({1'b0, b} & m);
        full = aa + bb + (s ? 33'd1 : {32'd0, cin});
        r.sum  = full[31:0] & mask_of(w);
        r.cout = full[w];
        r.ovf  = (aa[w-1] == bb[w-1]) && (full[w-1] != aa[w-1]);
        return r;
    endfunction

    // Scoreboard monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && o_out_valid) begin
                checks++;
                if ({o_sum, o_cout, o_ovf} !== prev_out) begin
                    errors++;
                    $display("FAIL stall_hold got %h want %h", {o_sum, o_cout, o_ovf}, prev_out);
                end
            end
            prev_stall = o_out_valid && !t_out_ready;
            prev_out   = {o_sum, o_cout, o_ovf};
            if (o_out_valid && t_out_ready) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output got sum=%h with nothing outstanding", o_sum);
                end else begin
                    res_t e;
                    e = sb_q.pop_front();
                    n_out++;
                    if ({o_sum, o_cout, o_ovf} !== e) begin
                        errors++;
                        $display("FAIL scoreboard sel=%0d got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                                 sel, o_sum, o_cout, o_ovf, e.sum, e.cout, e.ovf);
                    end
                end
            end
            if (t_in_valid && o_in_ready) begin
                sb_q.push_back(model(w_of(sel), t_in1, t_in2, t_cin, t_sub));
            end
        end
    end

    // Random backpressure, active only while rand_ready is set.
    always @(posedge clk) begin
        #1;
        if (rand_ready) t_out_ready = 1'($urandom_range(0, 1));
    end

    // Present one operation and return just after the edge that accepted it.
    task automatic send(input logic [31:0] a, b, input logic cin, s);
        logic acc;
        acc = 1'b0;
        t_in1 = a; t_in2 = b; t_cin = cin; t_sub = s; t_in_valid = 1'b1;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            acc = o_in_ready;
            @(posedge clk);
            #1;
        end
        t_in_valid = 1'b0;
        if (!acc) begin
            checks++; errors++;
            $display("FAIL accept_timeout sel=%0d in_ready stayed %b, want 1", sel, o_in_ready);
        end
    endtask

    // One operation with out_ready held high; lat counts edges after the
    // accepting edge until out_valid is seen (-1 if it never appears).
    task automatic do_op(input logic [31:0] a, b, input logic cin, s,
                         output res_t r, output int lat);
        send(a, b, cin, s);
        lat = 0;
        while (!o_out_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!o_out_valid) lat = -1;
        r = {o_sum, o_cout, o_ovf};
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 500 && sb_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout sel=%0d outstanding=%0d want 0", sel, sb_q.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; t_in_valid = 1'b0; t_out_ready = 1'b1;
        t_in1 = '0; t_in2 = '0; t_cin = 1'b0; t_sub = 1'b0; sel = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            sel = 2'(s);
            #1;
            checks++;
            if ({o_out_valid, o_sum, o_cout, o_ovf} !== 35'd0) begin
                errors++;
                $display("FAIL reset_state sel=%0d got valid=%b sum=%h cout=%b ovf=%b want all 0",
                         s, o_out_valid, o_sum, o_cout, o_ovf);
            end
        end
        sel = 2'd0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        checks++;
        if (o_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %b want 1", o_in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    // Latency: the accepting edge is the first of STAGES edges, so out_valid
    // is seen STAGES-1 edges after it.
    task automatic test_add(input logic [1:0] s);
        res_t r;
        int   lat;
        sel = s;
        do_op(32'h0000_000B, 32'h0000_0003, 1'b0, 1'b0, r, lat);
        checks++;
        if (r !== {32'h0000_000E, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL add_w%0d got sum=%h cout=%b ovf=%b want sum=0000000e cout=0 ovf=0",
                     w_of(s), r.sum, r.cout, r.ovf);
        end
        checks++;
        if (lat != stages_of(s) - 1) begin
            errors++;
            $display("FAIL add_latency_w%0d got %0d want %0d", w_of(s), lat, stages_of(s) - 1);
        end
    endtask

    task automatic test_carry_chain(input logic [1:0] s);
        logic [31:0] m, h;
        logic [31:0] a_t [2];
        logic [31:0] b_t [2];
        logic        c_t [2];
        res_t        e_t [2];
        res_t        r;
        int          lat;
        sel = s;
        m = mask_of(w_of(s));
        h = 32'd1 << (w_of(s) - 1);
        a_t[0] = m;        b_t[0] = 32'd0; c_t[0] = 1'b1; e_t[0] = {32'd0, 1'b1, 1'b0};
        a_t[1] = h - 32'd1; b_t[1] = 32'd1; c_t[1] = 1'b0; e_t[1] = {h, 1'b0, 1'b1};
        for (int i = 0; i < 2; i++) begin
            do_op(a_t[i], b_t[i], c_t[i], 1'b0, r, lat);
            checks++;
            if (r !== e_t[i]) begin
                errors++;
                $display("FAIL carry_w%0d_%0d got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                         w_of(s), i, r.sum, r.cout, r.ovf, e_t[i].sum, e_t[i].cout, e_t[i].ovf);
            end
            checks++;
            if (lat != stages_of(s) - 1) begin
                errors++;
                $display("FAIL carry_latency_w%0d got %0d want %0d", w_of(s), lat, stages_of(s) - 1);
            end
        end
    endtask

    // carry_in is set to 1 on every subtraction to confirm it is ignored.
    task automatic test_sub(input logic [1:0] s);
        logic [31:0] m, h;
        logic [31:0] a_t [3];
        logic [31:0] b_t [3];
        res_t        e_t [3];
        res_t        r;
        int          lat;
        sel = s;
        m = mask_of(w_of(s));
        h = 32'd1 << (w_of(s) - 1);
        a_t[0] = 32'd5; b_t[0] = 32'd7; e_t[0] = {m - 32'd1, 1'b0, 1'b0};
        a_t[1] = 32'd7; b_t[1] = 32'd5; e_t[1] = {32'd2, 1'b1, 1'b0};
        a_t[2] = h;     b_t[2] = 32'd1; e_t[2] = {h - 32'd1, 1'b1, 1'b1};
        for (int i = 0; i < 3; i++) begin
            do_op(a_t[i], b_t[i], 1'b1, 1'b1, r, lat);
            checks++;
            if (r !== e_t[i]) begin
                errors++;
                $display("FAIL sub_w%0d_%0d got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                         w_of(s), i, r.sum, r.cout, r.ovf, e_t[i].sum, e_t[i].cout, e_t[i].ovf);
            end
            checks++;
            if (lat != stages_of(s) - 1) begin
                errors++;
                $display("FAIL sub_latency_w%0d got %0d want %0d", w_of(s), lat, stages_of(s) - 1);
            end
        end
    endtask

    task automatic test_params();
        for (int s = 1; s < 3; s++) begin
            test_add(2'(s));
            test_carry_chain(2'(s));
            test_sub(2'(s));
        end
    endtask

    task automatic test_back_to_back();
        int t0, n0;
        sel = 2'd0; t_out_ready = 1'b1;
        n0 = n_out;
        t0 = cyc;
        for (int i = 0; i < 8; i++) begin
            send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        checks++;
        if (cyc - t0 != 8) begin
            errors++;
            $display("FAIL back_to_back_rate got %0d cycles want 8", cyc - t0);
        end
        drain();
        checks++;
        if (n_out - n0 != 8) begin
            errors++;
            $display("FAIL back_to_back_count got %0d want 8", n_out - n0);
        end
    endtask

    task automatic test_backpressure();
        int n0;
        for (int s = 0; s < 3; s++) begin
            sel = 2'(s);
            n0 = n_out;
            rand_ready = 1'b1;
            for (int i = 0; i < 10; i++) begin
                send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
            drain();
            rand_ready = 1'b0;
            t_out_ready = 1'b1;
            @(posedge clk);
            #1;
            checks++;
            if (n_out - n0 != 10) begin
                errors++;
                $display("FAIL backpressure_count_w%0d got %0d want 10", w_of(2'(s)), n_out - n0);
            end
        end
    endtask

    task automatic test_reset_midstream();
        res_t r;
        int   lat, seen;
        sel = 2'd0; t_out_ready = 1'b1;
        do_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, r, lat);
        for (int i = 0; i < 3; i++) send(32'h100 * i + 32'h1, 32'h7, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        checks++;
        if (o_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_valid got %b want 0", o_out_valid);
        end
        checks++;
        if (o_sum !== 32'd0) begin
            errors++;
            $display("FAIL midreset_sum got %h want 00000000", o_sum);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (o_out_valid) seen++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL midreset_ghost got %0d outputs after release want 0", seen);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add(2'd0);
        test_carry_chain(2'd0);
        test_sub(2'd0);
        test_params();
        test_back_to_back();
        test_backpressure();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
